// File: rtl/up_down_bounded_counter.sv
// Up/down counter bounded by runtime lo/hi limits, with per-bound wrap or saturate,
// parallel load, a sticky load flag and single-cycle overflow/underflow pulses.
module up_down_bounded_counter #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] count,
    output logic             ovf,
    output logic             unf,
    output logic             loaded,
    output logic             at_max,
    output logic             at_min,
    output logic             cfg_err
);

    logic [WIDTH-1:0] count_next;
    logic             ovf_next;
    logic             unf_next;

    assign at_max  = (count == hi);
    assign at_min  = (count == lo);
    assign cfg_err = (lo > hi);

    // Bound compare happens before the step, so +1/-1 never crosses 0 or all-ones.
    always_comb begin
        count_next = count;
        ovf_next   = 1'b0;
        unf_next   = 1'b0;
        if (load) begin
            count_next = load_val;
        end else if (en && !cfg_err) begin
            if (up) begin
                if (count < hi) begin
                    count_next = count + WIDTH'(1);
                end else if (sat) begin
                    count_next = hi;
                end else begin
                    count_next = lo;
                    ovf_next   = 1'b1;
                end
            end else begin
                if (count > lo) begin
                    count_next = count - WIDTH'(1);
                end else if (sat) begin
                    count_next = lo;
                end else begin
                    count_next = hi;
                    unf_next   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            count  <= RST_VAL;
            ovf    <= 1'b0;
            unf    <= 1'b0;
            loaded <= 1'b0;
        end else begin
            count <= count_next;
            ovf   <= ovf_next;
            unf   <= unf_next;
            if (load) begin
                loaded <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_up_down_bounded_counter.sv
// Scenario and randomized checks of up_down_bounded_counter against directed
// expectations and a behavioural integer model.
module tb_up_down_bounded_counter;

    localparam int         W       = 8;
    localparam logic [7:0] RST_VAL = 8'd0;

    logic         clk = 1'b0;
    logic         clr, en, up, sat, load;
    logic [W-1:0] load_val, lo, hi;
    logic [W-1:0] count;
    logic         ovf, unf, loaded, at_max, at_min, cfg_err;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int m_count;
    bit m_ovf, m_unf, m_loaded;

    up_down_bounded_counter #(.WIDTH(W), .RST_VAL(RST_VAL)) dut (
        .clk(clk), .clr(clr), .en(en), .up(up), .sat(sat), .load(load),
        .load_val(load_val), .lo(lo), .hi(hi), .count(count), .ovf(ovf),
        .unf(unf), .loaded(loaded), .at_max(at_max), .at_min(at_min),
        .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic drive_idle();
        clr = 0; en = 0; up = 1; sat = 0; load = 0; load_val = '0;
    endtask

    // Advance the model from the currently driven inputs, then clock the DUT.
    task automatic tick();
        int ilo, ihi;
        ilo = int'(lo);
        ihi = int'(hi);
        m_ovf = 0;
        m_unf = 0;
        if (clr) begin
            m_count  = int'(RST_VAL);
            m_loaded = 0;
        end else if (load) begin
            m_count  = int'(load_val);
            m_loaded = 1;
        end else if (en && ilo <= ihi) begin
            if (up) begin
                if (m_count < ihi) m_count = m_count + 1;
                else if (sat) m_count = ihi;
                else begin m_count = ilo; m_ovf = 1; end
            end else begin
                if (m_count > ilo) m_count = m_count - 1;
                else if (sat) m_count = ilo;
                else begin m_count = ihi; m_unf = 1; end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] v);
        load = 1; load_val = v; en = 0;
        tick();
        load = 0;
    endtask

    task automatic test_reset();
        drive_idle();
        lo = 8'd0; hi = 8'd255;
        clr = 1;
        tick();
        n_cmp++;
        if ({count, ovf, unf, loaded} !== {RST_VAL, 3'b000}) begin
            n_bad++; $display("FAIL reset_state: got %h exp %h", {count, ovf, unf, loaded}, {RST_VAL, 3'b000});
        end
        clr = 0; load = 1; load_val = 8'd7;
        tick();
        n_cmp++;
        if ({count, loaded} !== {8'd7, 1'b1}) begin
            n_bad++; $display("FAIL load_7: got %h exp %h", {count, loaded}, {8'd7, 1'b1});
        end
        load = 0; clr = 1;
        tick();
        clr = 0;
        n_cmp++;
        if ({count, loaded} !== {RST_VAL, 1'b0}) begin
            n_bad++; $display("FAIL reclear: got %h exp %h", {count, loaded}, {RST_VAL, 1'b0});
        end
    endtask

    task automatic test_wrap_up();
        logic [9:0] exp_v [4] = '{{8'd9, 2'b00}, {8'd10, 2'b01}, {8'd3, 2'b10}, {8'd4, 2'b00}};
        drive_idle();
        lo = 8'd3; hi = 8'd10;
        do_load(8'd8);
        en = 1; up = 1; sat = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if ({count, ovf, at_max} !== exp_v[i]) begin
                n_bad++; $display("FAIL wrap_up[%0d]: got %h exp %h", i, {count, ovf, at_max}, exp_v[i]);
            end
        end
        en = 0;
    endtask

    task automatic test_wrap_down_sat();
        logic [9:0] exp_w [2] = '{{8'd3, 2'b01}, {8'd10, 2'b10}};
        drive_idle();
        lo = 8'd3; hi = 8'd10;
        do_load(8'd4);
        en = 1; up = 0; sat = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if ({count, unf, at_min} !== exp_w[i]) begin
                n_bad++; $display("FAIL wrap_down[%0d]: got %h exp %h", i, {count, unf, at_min}, exp_w[i]);
            end
        end
        do_load(8'd4);
        en = 1; up = 0; sat = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({count, unf, at_min} !== {8'd3, 2'b01}) begin
                n_bad++; $display("FAIL sat_down[%0d]: got %h exp %h", i, {count, unf, at_min}, {8'd3, 2'b01});
            end
        end
        en = 0;
    endtask

    task automatic test_out_of_range();
        drive_idle();
        lo = 8'd3; hi = 8'd10;
        do_load(8'd200);
        en = 1; up = 1; sat = 0;
        tick();
        n_cmp++;
        if ({count, ovf} !== {8'd3, 1'b1}) begin
            n_bad++; $display("FAIL oor_high: got %h exp %h", {count, ovf}, {8'd3, 1'b1});
        end
        do_load(8'd1);
        en = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({count, ovf} !== {8'(2 + i), 1'b0}) begin
                n_bad++; $display("FAIL oor_low[%0d]: got %h exp %h", i, {count, ovf}, {8'(2 + i), 1'b0});
            end
        end
        en = 0;
    endtask

    task automatic test_priority();
        drive_idle();
        lo = 8'd3; hi = 8'd10;
        do_load(8'd10);
        // At hi in wrap mode: clr must win and suppress the pulse.
        clr = 1; load = 1; load_val = 8'd55; en = 1; up = 1; sat = 0;
        tick();
        n_cmp++;
        if ({count, ovf, loaded} !== {RST_VAL, 2'b00}) begin
            n_bad++; $display("FAIL clr_wins: got %h exp %h", {count, ovf, loaded}, {RST_VAL, 2'b00});
        end
        clr = 0; load = 1; load_val = 8'd9; en = 1;
        tick();
        n_cmp++;
        if ({count, loaded} !== {8'd9, 1'b1}) begin
            n_bad++; $display("FAIL load_over_en: got %h exp %h", {count, loaded}, {8'd9, 1'b1});
        end
        load = 0; en = 0;
    endtask

    task automatic test_cfg_err();
        drive_idle();
        lo = 8'd3; hi = 8'd10;
        do_load(8'd6);
        lo = 8'd12; hi = 8'd5;
        #1;
        n_cmp++;
        if (cfg_err !== 1'b1) begin
            n_bad++; $display("FAIL cfg_err_set: got %b exp 1", cfg_err);
        end
        en = 1; up = 1; sat = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if ({count, ovf, unf} !== {8'd6, 2'b00}) begin
                n_bad++; $display("FAIL cfg_hold[%0d]: got %h exp %h", i, {count, ovf, unf}, {8'd6, 2'b00});
            end
        end
        load = 1; load_val = 8'd9;
        tick();
        load = 0;
        n_cmp++;
        if (count !== 8'd9) begin
            n_bad++; $display("FAIL cfg_load: got %h exp %h", count, 8'd9);
        end
        lo = 8'd5; hi = 8'd5;
        #1;
        n_cmp++;
        if (cfg_err !== 1'b0) begin
            n_bad++; $display("FAIL cfg_err_eq: got %b exp 0", cfg_err);
        end
        en = 0;
    endtask

    task automatic test_back_to_back();
        drive_idle();
        lo = 8'd6; hi = 8'd6;
        do_load(8'd6);
        en = 1; up = 1; sat = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({count, ovf, unf} !== {8'd6, 2'b10}) begin
                n_bad++; $display("FAIL b2b_ovf[%0d]: got %h exp %h", i, {count, ovf, unf}, {8'd6, 2'b10});
            end
        end
        up = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if ({count, ovf, unf} !== {8'd6, 2'b01}) begin
                n_bad++; $display("FAIL b2b_unf[%0d]: got %h exp %h", i, {count, ovf, unf}, {8'd6, 2'b01});
            end
        end
        en = 0;
    endtask

    task automatic test_full_scale();
        logic [8:0] exp_u [3] = '{{8'd255, 1'b0}, {8'd0, 1'b1}, {8'd1, 1'b0}};
        logic [8:0] exp_d [2] = '{{8'd0, 1'b0}, {8'd255, 1'b1}};
        drive_idle();
        lo = 8'd0; hi = 8'd255;
        do_load(8'd254);
        en = 1; up = 1; sat = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({count, ovf} !== exp_u[i]) begin
                n_bad++; $display("FAIL full_up[%0d]: got %h exp %h", i, {count, ovf}, exp_u[i]);
            end
        end
        do_load(8'd254);
        en = 1; sat = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({count, ovf} !== {8'd255, 1'b0}) begin
                n_bad++; $display("FAIL full_sat[%0d]: got %h exp %h", i, {count, ovf}, {8'd255, 1'b0});
            end
        end
        do_load(8'd1);
        en = 1; up = 0; sat = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if ({count, unf} !== exp_d[i]) begin
                n_bad++; $display("FAIL full_down[%0d]: got %h exp %h", i, {count, unf}, exp_d[i]);
            end
        end
        en = 0;
    endtask

    task automatic test_random();
        logic [10:0] got, exp_v;
        drive_idle();
        lo = 8'd20; hi = 8'd40;
        for (int i = 0; i < 800; i++) begin
            clr      = ($urandom_range(0, 39) == 0);
            load     = ($urandom_range(0, 9) == 0);
            load_val = 8'($urandom_range(0, 255));
            en       = ($urandom_range(0, 3) != 0);
            up       = 1'($urandom);
            sat      = 1'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                lo = 8'($urandom_range(0, 200));
                hi = 8'($urandom_range(int'(lo), 255));
                if ($urandom_range(0, 7) == 0) begin
                    lo = 8'($urandom_range(0, 255));
                    hi = 8'($urandom_range(0, 255));
                end
            end
            tick();
            got   = {count, ovf, unf, loaded};
            exp_v = {8'(m_count), m_ovf, m_unf, m_loaded};
            n_cmp++;
            if (got !== exp_v) begin
                n_bad++; $display("FAIL rand_state[%0d]: got %h exp %h", i, got, exp_v);
            end
            n_cmp++;
            if ({at_max, at_min, cfg_err} !== {m_count == int'(hi), m_count == int'(lo), lo > hi}) begin
                n_bad++; $display("FAIL rand_flags[%0d]: got %b exp %b", i, {at_max, at_min, cfg_err},
                                  {m_count == int'(hi), m_count == int'(lo), lo > hi});
            end
        end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        lo = '0; hi = '0;
        test_reset();
        test_wrap_up();
        test_wrap_down_sat();
        test_out_of_range();
        test_priority();
        test_cfg_err();
        test_back_to_back();
        test_full_scale();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
